jt12_sh_wr_sched: RTL and testbench
===================================

// Module: jt12_sh_wr_sched
// PURPOSE
//  Write scheduler for a circulating per-slot shift register (channel/operator state loop).
//  - Owns the loop input and sweeps every stage to RSTVAL after reset.
//  - Recirculates the register output to its input; one value per slot.
//  - Injects a single pending host write exactly when the target slot passes the loop input.
//  - Sits between the register-write decoder and the STAGES-deep shifter.
// PARAMETERS
//  WIDTH   5   bits per slot entry
//  STAGES  24  shifter depth = number of slots (2..2**SLOTW)
//  SLOTW   5   slot index width
//  RSTVAL  0   value written to every slot during the init sweep
// PORTS
//  clk       in   1      clock; the shifter advances every clk
//  rst       in   1      synchronous reset, active-high
//  req       in   1      write request; sampled only while busy=0
//  req_slot  in   SLOTW  target slot of the request
//  req_data  in   WIDTH  value to write
//  busy      out  1      high in INIT and WAIT; requests are ignored while high
//  ack       out  1      one-cycle pulse: request finished (written or rejected)
//  err       out  1      one-cycle pulse with ack: req_slot>=STAGES, no write made
//  slot      out  SLOTW  slot index presented at sh_din this cycle
//  sh_drop   in   WIDTH  shifter output (oldest entry)
//  sh_din    out  WIDTH  shifter input
//  rd_data   out  WIDTH  previous contents of the written slot (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at an edge)
//   - next cycle: state=INIT, slot=0, busy=1, ack=0, err=0, rd_data=0.
//   - any pending request is discarded; no ack is issued for it.
//  Slot counter
//   - increments every clk in all states; wraps STAGES-1 -> 0.
//   - sh_drop in the cycle with slot=s holds the old value of slot s.
//  INIT
//   - sh_din=RSTVAL for STAGES cycles (slot 0..STAGES-1).
//   - when slot=STAGES-1 -> IDLE; busy falls in the first IDLE cycle.
//  IDLE
//   - sh_din=sh_drop (recirculate).
//   - req=1 with req_slot<STAGES: latch slot/data, -> WAIT, busy=1 next cycle.
//   - req=1 with req_slot>=STAGES: stay IDLE, ack=err=1 next cycle, busy stays 0.
//  WAIT
//   - sh_din=sh_drop except in the cycle where slot==pend_slot.
//   - in that cycle: sh_din=pend_data and the state returns to IDLE.
//   - ack=1 in the following cycle; busy=0 in that same cycle.
//   - a new request may be accepted in the ack cycle.
//  Latency
//   - write happens 1..STAGES cycles after the accept edge.
//   - matching at accept+1 is allowed.
//   - ack arrives 2..STAGES+1 cycles after the accept edge.
//  Boundaries
//   - req held high while busy: ignored, not queued.
//   - a level request is re-accepted after ack, so the host must drop req on ack.
//   - target slot = STAGES-1 followed by wrap to 0: no special case.
//   - rst during WAIT: write cancelled, INIT restarts from slot 0.
//   - ack and err are never high outside a single-cycle pulse.
// CONFIGURATION
//  JT12_SH_READBACK_EN
//   - defined: in the write cycle (or the reject cycle), rd_data<=sh_drop and is held
//     until the next write; a reject loads 0.
//   - undefined: rd_data is constant 0 and no capture register is built.
// TESTING
//  1. rst 1 cycle -> busy=1 for 24 cycles, sh_din=0 throughout, busy=0 at cycle 25, slot=0 then.
//  2. After init, req slot=5 data=5'h1A -> sh_din=5'h1A only at slot 5, ack 1 cycle later;
//     sh_drop shows 5'h1A every 24 cycles at slot 5; other slots stay 0.
//  3. req slot=30 -> ack=err=1 next cycle, no sh_din change, busy never set.
//  4. req slot=3 then req slot=9 while busy -> only slot 3 written, a single ack.
//  5. req slot=20, rst asserted before the match -> no write at 20, no ack, INIT sweep restarts.
//  6. (JT12_SH_READBACK_EN) write 5'h07 to slot 2, then 5'h11 to slot 2 -> rd_data=5'h00, then 5'h07.

Source files
------------

// File: rtl/jt12_sh_wr_sched_if.sv
// rtl/jt12_sh_wr_sched_if.sv - host write-request bus between the register decoder and jt12_sh_wr_sched
// Purpose: carries one slot write request and its busy/ack/err/readback response.
// Signals:
//   req, req_slot, req_data  host -> scheduler   write request, target slot, value
//   busy, ack, err           scheduler -> host   request gating and completion pulses
//   rd_data                  scheduler -> host   previous contents of the written slot
// Modports: master = host/decoder side, slave = scheduler side.
interface jt12_sh_wr_sched_if #(
    parameter int WIDTH = 5,
    parameter int SLOTW = 5
);
    logic             req;
    logic [SLOTW-1:0] req_slot;
    logic [WIDTH-1:0] req_data;
    logic             busy;
    logic             ack;
    logic             err;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output req, req_slot, req_data,
        input  busy, ack, err, rd_data
    );

    modport slave (
        input  req, req_slot, req_data,
        output busy, ack, err, rd_data
    );
endinterface

// File: rtl/jt12_sh_wr_sched.sv
// rtl/jt12_sh_wr_sched.sv - write scheduler for a circulating per-slot shift register
// Purpose: owns the input of a STAGES-deep slot loop. After reset it sweeps every
//   slot to RSTVAL, then recirculates the loop output and injects one pending host
//   write in the cycle the target slot passes the loop input.
// Ports:
//   clk_i      clock; the external shifter advances every cycle
//   rst_i      synchronous reset, active-high
//   host       jt12_sh_wr_sched_if.slave: req/req_slot/req_data in, busy/ack/err/rd_data out
//   slot_o     slot index presented on sh_din_o this cycle
//   sh_drop_i  shifter output (old value of slot_o)
//   sh_din_o   shifter input
// Optional feature: JT12_SH_READBACK_EN builds a capture register so rd_data returns
//   the previous contents of the written slot; otherwise rd_data is tied to 0.
module jt12_sh_wr_sched #(
    parameter int               WIDTH  = 5,
    parameter int               STAGES = 24,
    parameter int               SLOTW  = 5,
    parameter logic [WIDTH-1:0] RSTVAL = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    jt12_sh_wr_sched_if.slave        host,
    output logic [SLOTW-1:0]         slot_o,
    input  logic [WIDTH-1:0]         sh_drop_i,
    output logic [WIDTH-1:0]         sh_din_o
);

    localparam logic [SLOTW-1:0] LAST_SLOT = SLOTW'(STAGES - 1);
    // One extra bit so STAGES == 2**SLOTW still compares correctly.
    localparam logic [SLOTW:0]   NUM_SLOTS = (SLOTW + 1)'(STAGES);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [SLOTW-1:0] slot_q, slot_d;
    logic [SLOTW-1:0] pend_slot_q, pend_slot_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    // Free-running slot counter, independent of the FSM.
    assign slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            slot_q      <= '0;
            pend_slot_q <= '0;
            pend_data_q <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            pend_slot_q <= pend_slot_d;
            pend_data_q <= pend_data_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_slot_d = pend_slot_q;
        pend_data_d = pend_data_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        sh_din_o    = sh_drop_i;
        case (state_q)
            ST_INIT: begin
                sh_din_o = RSTVAL;
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (host.req) begin
                    if ({1'b0, host.req_slot} < NUM_SLOTS) begin
                        pend_slot_d = host.req_slot;
                        pend_data_d = host.req_data;
                        state_d     = ST_WAIT;
                    end else begin
                        // Out-of-range slot: answer immediately, loop untouched.
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (slot_q == pend_slot_q) begin
                    sh_din_o = pend_data_q;
                    ack_d    = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign slot_o    = slot_q;
    assign host.busy = (state_q != ST_IDLE);
    assign host.ack  = ack_q;
    assign host.err  = err_q;

`ifdef JT12_SH_READBACK_EN
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // ack_d marks both the write cycle and the reject cycle; err_d tells them apart.
    always_comb begin
        rd_data_d = rd_data_q;
        if (ack_d) begin
            rd_data_d = err_d ? '0 : sh_drop_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign host.rd_data = rd_data_q;
`else
    assign host.rd_data = '0;
`endif

endmodule

// File: tb/tb_jt12_sh_wr_sched.sv
// tb/tb_jt12_sh_wr_sched.sv - self-checking bench for jt12_sh_wr_sched
module tb_jt12_sh_wr_sched;
    localparam int WIDTH  = 5;
    localparam int STAGES = 24;
    localparam int SLOTW  = 5;
    localparam logic [WIDTH-1:0] RSTVAL = '0;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fill = 1'b0;
    logic [SLOTW-1:0] slot;
    logic [WIDTH-1:0] sh_drop;
    logic [WIDTH-1:0] sh_din;
    logic [WIDTH-1:0] shreg [STAGES];

    int n_tests = 0;
    int n_fail  = 0;
    int cur_slot = 0;
    logic [WIDTH-1:0] exp_mem [STAGES];

    jt12_sh_wr_sched_if #(.WIDTH(WIDTH), .SLOTW(SLOTW)) hif ();

    jt12_sh_wr_sched #(
        .WIDTH(WIDTH), .STAGES(STAGES), .SLOTW(SLOTW), .RSTVAL(RSTVAL)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .host     (hif.slave),
        .slot_o   (slot),
        .sh_drop_i(sh_drop),
        .sh_din_o (sh_din)
    );

    always #5 clk = ~clk;

    // External STAGES-deep shifter; fill loads garbage so the init sweep is visible.
    assign sh_drop = shreg[STAGES-1];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < STAGES; i++) shreg[i] <= WIDTH'($urandom_range(1, 31));
        end else begin
            shreg[0] <= sh_din;
            for (int i = 1; i < STAGES; i++) shreg[i] <= shreg[i-1];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cur_slot = (cur_slot + 1) % STAGES;
    endtask

    task automatic test_reset();
        hif.req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_slot = 0;
        n_tests++; if (hif.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", hif.busy); end
        n_tests++; if (hif.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", hif.ack); end
        n_tests++; if (hif.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", hif.err); end
        n_tests++; if (hif.rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", hif.rd_data); end
        for (int i = 0; i < STAGES; i++) begin
            n_tests++; if (hif.busy !== 1'b1) begin n_fail++; $display("FAIL init_busy: cycle %0d got %b want 1", i, hif.busy); end
            n_tests++; if (sh_din !== RSTVAL) begin n_fail++; $display("FAIL init_sh_din: cycle %0d got %h want %h", i, sh_din, RSTVAL); end
            n_tests++; if (slot !== SLOTW'(i)) begin n_fail++; $display("FAIL init_slot: got %0d want %0d", slot, i); end
            n_tests++; if (hif.ack !== 1'b0) begin n_fail++; $display("FAIL init_ack: cycle %0d got %b want 0", i, hif.ack); end
            step();
        end
        n_tests++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL init_done_busy: got %b want 0", hif.busy); end
        n_tests++; if (slot !== '0) begin n_fail++; $display("FAIL init_done_slot: got %0d want 0", slot); end
        for (int i = 0; i < STAGES; i++) exp_mem[i] = RSTVAL;
    endtask

    // Idle cycles: the loop must recirculate and hold the modelled contents.
    task automatic test_idle(input int n);
        for (int k = 0; k < n; k++) begin
            n_tests++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", hif.busy); end
            n_tests++; if (hif.ack !== 1'b0 || hif.err !== 1'b0) begin n_fail++; $display("FAIL idle_ack_err: got %b%b want 00", hif.ack, hif.err); end
            n_tests++; if (slot !== SLOTW'(cur_slot)) begin n_fail++; $display("FAIL idle_slot: got %0d want %0d", slot, cur_slot); end
            n_tests++; if (sh_drop !== exp_mem[cur_slot]) begin n_fail++; $display("FAIL idle_sh_drop: slot %0d got %h want %h", cur_slot, sh_drop, exp_mem[cur_slot]); end
            n_tests++; if (sh_din !== exp_mem[cur_slot]) begin n_fail++; $display("FAIL idle_sh_din: slot %0d got %h want %h", cur_slot, sh_din, exp_mem[cur_slot]); end
            step();
        end
    endtask

    // Valid write issued in the current (idle or ack) cycle; ends in the ack cycle,
    // or one cycle later when settle is set.
    task automatic test_write(input int tgt, input logic [WIDTH-1:0] data, input bit settle);
        int d;
        logic [WIDTH-1:0] old, exp_rd;
        d = ((tgt - cur_slot - 1 + 2 * STAGES) % STAGES) + 1;
        hif.req = 1'b1;
        hif.req_slot = SLOTW'(tgt);
        hif.req_data = data;
        step();
        hif.req = 1'b0;
        for (int k = 1; k <= d; k++) begin
            n_tests++; if (hif.busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: k=%0d got %b want 1", k, hif.busy); end
            n_tests++; if (hif.ack !== 1'b0) begin n_fail++; $display("FAIL wait_ack: k=%0d got %b want 0", k, hif.ack); end
            n_tests++; if (sh_drop !== exp_mem[cur_slot]) begin n_fail++; $display("FAIL wait_sh_drop: slot %0d got %h want %h", cur_slot, sh_drop, exp_mem[cur_slot]); end
            if (k == d) begin
                n_tests++; if (sh_din !== data) begin n_fail++; $display("FAIL write_sh_din: slot %0d got %h want %h", tgt, sh_din, data); end
            end else begin
                n_tests++; if (sh_din !== exp_mem[cur_slot]) begin n_fail++; $display("FAIL wait_sh_din: slot %0d got %h want %h", cur_slot, sh_din, exp_mem[cur_slot]); end
            end
            step();
        end
        old = exp_mem[tgt];
        exp_mem[tgt] = data;
`ifdef JT12_SH_READBACK_EN
        exp_rd = old;
`else
        exp_rd = '0;
`endif
        n_tests++; if (hif.ack !== 1'b1) begin n_fail++; $display("FAIL write_ack: slot %0d got %b want 1", tgt, hif.ack); end
        n_tests++; if (hif.err !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", hif.err); end
        n_tests++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL ack_busy: got %b want 0", hif.busy); end
        n_tests++; if (hif.rd_data !== exp_rd) begin n_fail++; $display("FAIL write_rd_data: slot %0d got %h want %h", tgt, hif.rd_data, exp_rd); end
        if (settle) begin
            step();
            n_tests++; if (hif.ack !== 1'b0) begin n_fail++; $display("FAIL ack_pulse: got %b want 0", hif.ack); end
        end
    endtask

    task automatic test_reject(input int tgt);
        hif.req = 1'b1;
        hif.req_slot = SLOTW'(tgt);
        hif.req_data = WIDTH'($urandom);
        step();
        hif.req = 1'b0;
        n_tests++; if (hif.ack !== 1'b1 || hif.err !== 1'b1) begin n_fail++; $display("FAIL reject_ack_err: slot %0d got %b%b want 11", tgt, hif.ack, hif.err); end
        n_tests++; if (hif.busy !== 1'b0) begin n_fail++; $display("FAIL reject_busy: got %b want 0", hif.busy); end
        n_tests++; if (sh_din !== exp_mem[cur_slot]) begin n_fail++; $display("FAIL reject_sh_din: got %h want %h", sh_din, exp_mem[cur_slot]); end
        n_tests++; if (hif.rd_data !== '0) begin n_fail++; $display("FAIL reject_rd_data: got %h want 0", hif.rd_data); end
        step();
        n_tests++; if (hif.ack !== 1'b0 || hif.err !== 1'b0) begin n_fail++; $display("FAIL reject_pulse: got %b%b want 00", hif.ack, hif.err); end
    endtask

    // Second request held high while busy must neither queue nor write.
    task automatic test_busy_ignored();
        int d;
        logic [WIDTH-1:0] a, b;
        a = WIDTH'($urandom_range(1, 31));
        b = ~exp_mem[9];
        d = ((3 - cur_slot - 1 + 2 * STAGES) % STAGES) + 1;
        hif.req = 1'b1;
        hif.req_slot = SLOTW'(3);
        hif.req_data = a;
        step();
        hif.req_slot = SLOTW'(9);
        hif.req_data = b;
        for (int k = 1; k <= d; k++) begin
            n_tests++; if (hif.ack !== 1'b0) begin n_fail++; $display("FAIL busy_ack: k=%0d got %b want 0", k, hif.ack); end
            n_tests++; if (sh_din !== ((k == d) ? a : exp_mem[cur_slot])) begin n_fail++; $display("FAIL busy_sh_din: slot %0d got %h want %h", cur_slot, sh_din, (k == d) ? a : exp_mem[cur_slot]); end
            step();
        end
        exp_mem[3] = a;
        n_tests++; if (hif.ack !== 1'b1) begin n_fail++; $display("FAIL busy_single_ack: got %b want 1", hif.ack); end
        hif.req = 1'b0;
        step();
        test_idle(2 * STAGES);
    endtask

    // rst during WAIT cancels the write and restarts the sweep.
    task automatic test_rst_in_wait();
        test_idle((STAGES - cur_slot) % STAGES);
        hif.req = 1'b1;
        hif.req_slot = SLOTW'(20);
        hif.req_data = ~exp_mem[20];
        step();
        hif.req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++; if (sh_din !== exp_mem[cur_slot]) begin n_fail++; $display("FAIL rstwait_sh_din: slot %0d got %h want %h", cur_slot, sh_din, exp_mem[cur_slot]); end
            step();
        end
        test_reset();
        test_idle(2 * STAGES);
    endtask

    task automatic test_back_to_back();
        test_write(STAGES - 1, WIDTH'($urandom_range(1, 31)), 1'b0);
        test_write((cur_slot + 1) % STAGES, WIDTH'($urandom_range(1, 31)), 1'b0);
        test_write(cur_slot, WIDTH'($urandom_range(1, 31)), 1'b1);
        test_idle(STAGES);
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 9) < 2) test_reject($urandom_range(STAGES, 31));
            else test_write($urandom_range(0, STAGES - 1), WIDTH'($urandom), 1'b1);
            test_idle($urandom_range(0, 3));
        end
        test_idle(STAGES);
    endtask

    initial begin
        hif.req = 1'b0;
        hif.req_slot = '0;
        hif.req_data = '0;
        fill = 1'b1;
        @(posedge clk);
        #1;
        fill = 1'b0;
        test_reset();
        test_write(5, 5'h1A, 1'b1);
        test_idle(2 * STAGES);
        test_write(2, 5'h07, 1'b1);
        test_write(2, 5'h11, 1'b1);
        test_reject(30);
        test_idle(STAGES);
        test_busy_ignored();
        test_back_to_back();
        test_random();
        test_rst_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
